setpoint_controller: RTL and testbench

Consumes the single-cycle up/down/sign pulses produced by the button auto-repeat pulse generator and maintains a sign-magnitude setpoint for the signal generator datapath. The controller accelerates the step size while a button is held and saturates at configured limits. It presents each changed setpoint to the downstream datapath over a valid/ready handshake. It sits between the front-panel pulse generator and the generator configuration registers.

---
 rtl/setpoint_pkg.sv | 20 ++
 rtl/setpoint_controller_if.sv | 27 ++
 rtl/setpoint_controller_repeat_accelerator.sv | 58 +++++
 rtl/setpoint_controller.sv | 130 +++++++++++++
 tb/tb_setpoint_controller.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/setpoint_pkg.sv
// Shared types and default limits for the front-panel setpoint controller.
package setpoint_pkg;

   typedef enum logic {
      Idle,
      Offer
   } state_t;

   typedef enum logic [1:0] {
      DirNone,
      DirUp,
      DirDown
   } dir_t;

   localparam int unsigned DefWidth     = 16;
   localparam int unsigned DefMaxValue  = 9999;
   localparam int unsigned DefFastAfter = 8;
   localparam int unsigned DefFastStep  = 10;

endpackage

// File: rtl/setpoint_controller_if.sv
// Setpoint offer channel towards the generator configuration registers.
interface setpoint_controller_if
   import setpoint_pkg::*;
#(
   parameter int unsigned Width = DefWidth
);

   logic [Width-1:0] oMagnitude;
   logic             oNegative;
   logic             oValid;
   logic             iReady;

   modport master (
      output oMagnitude,
      output oNegative,
      output oValid,
      input  iReady
   );

   modport slave (
      input  oMagnitude,
      input  oNegative,
      input  oValid,
      output iReady
   );

endinterface

// File: rtl/setpoint_controller_repeat_accelerator.sv
// Tracks consecutive same-direction pulses while a button is held and
// switches the step size from 1 to the fast step once enough have arrived.
module repeat_accelerator
   import setpoint_pkg::*;
#(
   parameter int unsigned Width     = DefWidth,
   parameter int unsigned FastAfter = DefFastAfter,
   parameter int unsigned FastStep  = DefFastStep
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             up_i,
   input  logic             down_i,
   input  logic             held_i,
   output logic [Width-1:0] step_o,
   output logic             fast_o
);

   localparam int unsigned CntW = $clog2(FastAfter + 1);

   logic [CntW-1:0] count_q, count_d;
   dir_t            dir_q, dir_d;
   dir_t            pulse_dir;

   // Next repeat count / direction: release clears, direction change reloads.
   always_comb begin
      count_d   = count_q;
      dir_d     = dir_q;
      pulse_dir = up_i ? DirUp : DirDown;
      if (!held_i) begin
         count_d = '0;
      end else if (up_i || down_i) begin
         if (pulse_dir == dir_q) begin
            if (count_q < CntW'(FastAfter)) begin
               count_d = count_q + CntW'(1);
            end
         end else begin
            count_d = CntW'(1);
            dir_d   = pulse_dir;
         end
      end
   end

   // Repeat state registers.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         count_q <= '0;
         dir_q   <= DirNone;
      end else begin
         count_q <= count_d;
         dir_q   <= dir_d;
      end
   end

   assign fast_o = (count_q >= CntW'(FastAfter));
   assign step_o = fast_o ? Width'(FastStep) : Width'(1);

endmodule

// File: rtl/setpoint_controller.sv
// Sign-magnitude setpoint controller: applies prioritised button pulses to a
// working value with acceleration and clamping, and offers each changed value
// downstream over a valid/ready handshake.
module setpoint_controller
   import setpoint_pkg::*;
#(
   parameter int unsigned Width     = DefWidth,
   parameter int unsigned MaxValue  = DefMaxValue,
   parameter int unsigned FastAfter = DefFastAfter,
   parameter int unsigned FastStep  = DefFastStep
) (
   input  logic Clock,
   input  logic Reset,
   input  logic iUpPulse,
   input  logic iDownPulse,
   input  logic iSignPulse,
   input  logic iHeld,
   output logic oFast,
   setpoint_controller_if.master bus
);

   localparam logic [Width:0] MaxExt = (Width + 1)'(MaxValue);

   logic             up_eff, down_eff;
   logic [Width-1:0] step;
   logic [Width:0]   sum, diff;
   logic [Width-1:0] new_mag;
   logic             new_neg;
   logic             changed;

   logic [Width-1:0] work_mag_q, work_mag_d;
   logic             work_neg_q, work_neg_d;
   logic [Width-1:0] out_mag_q, out_mag_d;
   logic             out_neg_q, out_neg_d;
   logic             pending_q, pending_d;
   state_t           state_q, state_d;

   // Sign beats up beats down; dropped pulses never reach the accelerator.
   assign up_eff   = iUpPulse & ~iSignPulse;
   assign down_eff = iDownPulse & ~iSignPulse & ~iUpPulse;

   repeat_accelerator #(
      .Width    (Width),
      .FastAfter(FastAfter),
      .FastStep (FastStep)
   ) u_accel (
      .Clock (Clock),
      .Reset (Reset),
      .up_i  (up_eff),
      .down_i(down_eff),
      .held_i(iHeld),
      .step_o(step),
      .fast_o(oFast)
   );

   // Working value update with one guard bit for clamping at both limits.
   always_comb begin
      sum     = {1'b0, work_mag_q} + {1'b0, step};
      diff    = {1'b0, work_mag_q} - {1'b0, step};
      new_mag = work_mag_q;
      new_neg = work_neg_q;
      if (iSignPulse) begin
         if (work_mag_q != '0) begin
            new_neg = ~work_neg_q;
         end
      end else if (up_eff) begin
         new_mag = (sum > MaxExt) ? MaxExt[Width-1:0] : sum[Width-1:0];
      end else if (down_eff) begin
         new_mag = diff[Width] ? '0 : diff[Width-1:0];
      end
      if (new_mag == '0) begin
         new_neg = 1'b0;
      end
      changed    = (new_mag != work_mag_q) || (new_neg != work_neg_q);
      work_mag_d = new_mag;
      work_neg_d = new_neg;
   end

   // Offer FSM; a change arriving as Pending is consumed re-arms it, so the
   // pre-update value is offered now and the new one follows.
   always_comb begin
      state_d   = state_q;
      out_mag_d = out_mag_q;
      out_neg_d = out_neg_q;
      pending_d = pending_q;
      case (state_q)
         Idle: begin
            if (pending_q) begin
               out_mag_d = work_mag_q;
               out_neg_d = work_neg_q;
               pending_d = 1'b0;
               state_d   = Offer;
            end
         end
         Offer: begin
            if (bus.iReady) begin
               state_d = Idle;
            end
         end
         default: state_d = Idle;
      endcase
      if (changed) begin
         pending_d = 1'b1;
      end
   end

   // Work, offered value, pending flag and FSM state registers.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         work_mag_q <= '0;
         work_neg_q <= 1'b0;
         out_mag_q  <= '0;
         out_neg_q  <= 1'b0;
         pending_q  <= 1'b0;
         state_q    <= Idle;
      end else begin
         work_mag_q <= work_mag_d;
         work_neg_q <= work_neg_d;
         out_mag_q  <= out_mag_d;
         out_neg_q  <= out_neg_d;
         pending_q  <= pending_d;
         state_q    <= state_d;
      end
   end

   assign bus.oMagnitude = out_mag_q;
   assign bus.oNegative  = out_neg_q;
   assign bus.oValid     = (state_q == Offer);

endmodule

// File: tb/tb_setpoint_controller.sv
// Self-checking bench for setpoint_controller: vector table, directed
// corner-case sequences and a randomized run against a reference model.
module tb_setpoint_controller;

   localparam int W    = 16;
   localparam int MAXV = 9999;
   localparam int FA   = 8;
   localparam int FS   = 10;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   logic up = 1'b0, dn = 1'b0, sg = 1'b0, held = 1'b0;
   logic oFast;

   setpoint_controller_if #(.Width(W)) bus ();

   setpoint_controller #(
      .Width    (W),
      .MaxValue (MAXV),
      .FastAfter(FA),
      .FastStep (FS)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .iUpPulse  (up),
      .iDownPulse(dn),
      .iSignPulse(sg),
      .iHeld     (held),
      .oFast     (oFast),
      .bus       (bus)
   );

   always #5 Clock = ~Clock;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   // Reference model state (plain integers)
   int m_work = 0, m_cnt = 0, m_last = 0, m_omag = 0;
   bit m_neg = 0, m_pend = 0, m_offer = 0, m_oneg = 0;

   typedef struct {
      bit rst, u, d, s, h, r;
      int mag;
      bit neg, valid, fast;
   } vec_t;

   vec_t vt[8];

   task automatic check(input string name, input int got, input int exp);
      total++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   // One clock of the specification's rules applied to the model.
   task automatic model_edge(input bit u, d, s, h, r, rs);
      int nw, step, pd;
      bit nn, chg;
      if (rs) begin
         m_work = 0; m_neg = 0; m_pend = 0; m_cnt = 0; m_last = 0;
         m_offer = 0; m_omag = 0; m_oneg = 0;
         return;
      end
      step = (m_cnt >= FA) ? FS : 1;
      nw = m_work;
      nn = m_neg;
      if (s) begin
         if (m_work != 0) nn = !m_neg;
      end else if (u) begin
         nw = (m_work + step > MAXV) ? MAXV : m_work + step;
      end else if (d) begin
         nw = (m_work - step < 0) ? 0 : m_work - step;
      end
      if (nw == 0) nn = 0;
      chg = (nw != m_work) || (nn != m_neg);
      if (!h) m_cnt = 0;
      else if (!s && (u || d)) begin
         pd = u ? 1 : 2;
         if (pd == m_last) m_cnt = (m_cnt < FA) ? m_cnt + 1 : FA;
         else begin
            m_cnt = 1;
            m_last = pd;
         end
      end
      if (!m_offer) begin
         if (m_pend) begin
            m_omag = m_work;
            m_oneg = m_neg;
            m_pend = 0;
            m_offer = 1;
         end
      end else if (r) m_offer = 0;
      if (chg) m_pend = 1;
      m_work = nw;
      m_neg = nn;
   endtask

   task automatic tick(input bit u, d, s, h, r, rs);
      int gm, em;
      @(negedge Clock);
      up = u; dn = d; sg = s; held = h; bus.iReady = r; Reset = rs;
      @(posedge Clock);
      model_edge(u, d, s, h, r, rs);
      #1;
      cyc++;
      gm = int'(bus.oMagnitude);
      em = m_omag;
      total++;
      if (gm == em && bus.oNegative == m_oneg && bus.oValid == m_offer &&
          oFast == (m_cnt >= FA))
         passed++;
      else
         $display("FAIL model cycle %0d: mag/neg/valid/fast got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                  cyc, gm, bus.oNegative, bus.oValid, oFast, em, m_oneg, m_offer, (m_cnt >= FA));
   endtask

   task automatic idle(input int n, input bit h, input bit r);
      repeat (n) tick(0, 0, 0, h, r, 0);
   endtask

   task automatic do_reset();
      tick(0, 0, 0, 0, 1, 1);
   endtask

   initial begin
      int exp_mag;
      int vcount;
      bus.iReady = 1'b1;

      // Reset then three slow up pulses, offers 1, 2, 3 separated by gaps
      vt[0] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
      vt[1] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
      vt[2] = '{0, 0, 0, 0, 0, 1, 1, 0, 1, 0};
      vt[3] = '{0, 1, 0, 0, 0, 1, 1, 0, 0, 0};
      vt[4] = '{0, 0, 0, 0, 0, 1, 2, 0, 1, 0};
      vt[5] = '{0, 1, 0, 0, 0, 1, 2, 0, 0, 0};
      vt[6] = '{0, 0, 0, 0, 0, 1, 3, 0, 1, 0};
      vt[7] = '{0, 0, 0, 0, 0, 1, 3, 0, 0, 0};
      foreach (vt[i]) begin
         tick(vt[i].u, vt[i].d, vt[i].s, vt[i].h, vt[i].r, vt[i].rst);
         check($sformatf("vec%0d_mag", i), int'(bus.oMagnitude), vt[i].mag);
         check($sformatf("vec%0d_neg", i), int'(bus.oNegative), int'(vt[i].neg));
         check($sformatf("vec%0d_valid", i), int'(bus.oValid), int'(vt[i].valid));
         check($sformatf("vec%0d_fast", i), int'(oFast), int'(vt[i].fast));
      end

      // Acceleration while held, then release
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         tick(1, 0, 0, 1, 1, 0);
         tick(0, 0, 0, 1, 1, 0);
         exp_mag = (k <= FA) ? k : FA + FS * (k - FA);
         check("accel_valid", int'(bus.oValid), 1);
         check("accel_mag", int'(bus.oMagnitude), exp_mag);
         check("accel_fast", int'(oFast), (k >= FA) ? 1 : 0);
      end
      tick(0, 0, 0, 0, 1, 0);
      tick(1, 0, 0, 0, 1, 0);
      tick(0, 0, 0, 0, 1, 0);
      check("release_mag", int'(bus.oMagnitude), 49);
      check("release_valid", int'(bus.oValid), 1);
      check("release_fast", int'(oFast), 0);

      // Upper clamp: reach 9995 accelerated, then 9999, then saturate
      do_reset();
      repeat (7) tick(1, 0, 0, 1, 1, 0);
      idle(1, 0, 1);
      repeat (FA + 998) tick(1, 0, 0, 1, 1, 0);
      idle(3, 1, 1);
      check("pre_max_mag", int'(bus.oMagnitude), 9995);
      check("pre_max_fast", int'(oFast), 1);
      check("pre_max_valid", int'(bus.oValid), 0);
      tick(1, 0, 0, 1, 1, 0);
      tick(0, 0, 0, 1, 1, 0);
      check("max_mag", int'(bus.oMagnitude), MAXV);
      check("max_valid", int'(bus.oValid), 1);
      idle(1, 1, 1);
      vcount = 0;
      tick(1, 0, 0, 1, 1, 0);
      vcount += int'(bus.oValid);
      repeat (2) begin
         tick(0, 0, 0, 1, 1, 0);
         vcount += int'(bus.oValid);
      end
      check("saturated_no_offer", vcount, 0);

      // Lower clamp from -2, sign ignored at zero
      do_reset();
      tick(1, 0, 0, 0, 1, 0);
      tick(1, 0, 0, 0, 1, 0);
      tick(0, 0, 1, 0, 1, 0);
      idle(3, 0, 1);
      check("neg2_mag", int'(bus.oMagnitude), 2);
      check("neg2_neg", int'(bus.oNegative), 1);
      tick(0, 1, 0, 0, 1, 0);
      tick(0, 0, 0, 0, 1, 0);
      check("down1_mag", int'(bus.oMagnitude), 1);
      check("down1_neg", int'(bus.oNegative), 1);
      check("down1_valid", int'(bus.oValid), 1);
      tick(0, 1, 0, 0, 1, 0);
      tick(0, 0, 0, 0, 1, 0);
      check("down0_mag", int'(bus.oMagnitude), 0);
      check("down0_neg", int'(bus.oNegative), 0);
      check("down0_valid", int'(bus.oValid), 1);
      tick(0, 1, 0, 0, 1, 0);
      tick(0, 0, 0, 0, 1, 0);
      check("down_sat_valid", int'(bus.oValid), 0);
      tick(0, 0, 1, 0, 1, 0);
      tick(0, 0, 0, 0, 1, 0);
      check("sign_zero_valid", int'(bus.oValid), 0);
      check("sign_zero_neg", int'(bus.oNegative), 0);

      // Back-pressure coalesces updates into one later offer
      do_reset();
      repeat (5) tick(1, 0, 0, 0, 0, 0);
      idle(3, 0, 0);
      check("stall_valid", int'(bus.oValid), 1);
      check("stall_mag", int'(bus.oMagnitude), 1);
      tick(0, 0, 0, 0, 1, 0);
      check("accept_gap", int'(bus.oValid), 0);
      tick(0, 0, 0, 0, 1, 0);
      check("coalesced_valid", int'(bus.oValid), 1);
      check("coalesced_mag", int'(bus.oMagnitude), 5);
      vcount = 0;
      repeat (3) begin
         tick(0, 0, 0, 0, 1, 0);
         vcount += int'(bus.oValid);
      end
      check("single_followup", vcount, 0);

      // Sign beats up; reset during an offer
      do_reset();
      repeat (4) tick(1, 0, 0, 0, 1, 0);
      idle(3, 0, 1);
      tick(1, 0, 1, 0, 1, 0);
      tick(0, 0, 0, 0, 1, 0);
      check("signup_mag", int'(bus.oMagnitude), 4);
      check("signup_neg", int'(bus.oNegative), 1);
      check("signup_valid", int'(bus.oValid), 1);
      tick(0, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 1);
      check("rst_valid", int'(bus.oValid), 0);
      check("rst_mag", int'(bus.oMagnitude), 0);
      check("rst_neg", int'(bus.oNegative), 0);
      check("rst_fast", int'(oFast), 0);
      idle(2, 0, 1);
      check("rst_work_cleared", int'(bus.oValid), 0);

      // Randomized run against the model (checked inside tick)
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bit ru, rd, rs_, rh, rr, rrst;
         int pu;
         pu   = (i % 1200 < 700) ? 2 : 5;
         ru   = ($urandom_range(0, pu - 1) == 0);
         rd   = ($urandom_range(0, 6 - pu) == 0);
         rs_  = ($urandom_range(0, 15) == 0);
         rh   = ($urandom_range(0, 19) != 0);
         rr   = ($urandom_range(0, 2) != 0);
         rrst = ($urandom_range(0, 799) == 0);
         tick(ru, rd, rs_, rh, rr, rrst);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
